// File: rtl/key_mode_if.sv
// Bundle of key pins, debounced key events and mode/speed outputs between the
// key front end and its neighbours.
//   keys_in      raw key pins (towards the controller)
//   key_level    debounced pressed level, 1 = pressed
//   key_press    1-cycle pulse on debounced press
//   key_release  1-cycle pulse on debounced release
//   key_long     1-cycle pulse once per press after the long-press threshold
//   mode, speed  current LED mode and speed index
//   mode_changed 1-cycle pulse when mode or speed takes a new value
// master: the side driving the pins (board / bench); slave: key_mode_ctrl.
interface key_mode_if #(
  parameter int NUM_KEYS = 4
);
  logic [NUM_KEYS-1:0] keys_in;
  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;
  logic [NUM_KEYS-1:0] key_long;
  logic [1:0]          mode;
  logic [1:0]          speed;
  logic                mode_changed;

  modport master (
    output keys_in,
    input  key_level, key_press, key_release, key_long,
    input  mode, speed, mode_changed
  );

  modport slave (
    input  keys_in,
    output key_level, key_press, key_release, key_long,
    output mode, speed, mode_changed
  );
endinterface

// File: rtl/key_mode_ctrl.sv
// Key front end for the LED marquee: synchronises and debounces NUM_KEYS
// push-buttons, emits level/press/release/long-press events, and owns the
// LED mode (key0 press steps it, key1 long press clears mode and speed) and
// speed (key1 short press steps it).
// Ports:
//   clk  system clock
//   rst  asynchronous reset, active-high
//   bus  key_mode_if slave: keys_in in; key_level, key_press, key_release,
//        key_long, mode, speed, mode_changed out
module key_mode_ctrl #(
  parameter int CLK_FREQ       = 200_000_000,
  parameter int DEBOUNCE_MS    = 20,
  parameter int LONG_MS        = 1000,
  parameter int NUM_KEYS       = 4,
  parameter int KEY_ACTIVE_LOW = 1,
  parameter int MODE_COUNT     = 3
) (
  input  logic       clk,
  input  logic       rst,
  key_mode_if.slave  bus
);

  localparam int DB_CYCLES   = CLK_FREQ / 1000 * DEBOUNCE_MS;
  localparam int LONG_CYCLES = CLK_FREQ / 1000 * LONG_MS;
  localparam int DB_W        = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int HOLD_W      = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;

  localparam logic [DB_W-1:0]     DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [1:0]          MODE_LAST = 2'(MODE_COUNT - 1);
  // Released pin level, so a reset never looks like a press.
  localparam logic [NUM_KEYS-1:0] SYNC_IDLE =
    (KEY_ACTIVE_LOW != 0) ? {NUM_KEYS{1'b1}} : {NUM_KEYS{1'b0}};

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } key_state_t;

  logic [NUM_KEYS-1:0] sync1_q, sync2_q;
  logic [NUM_KEYS-1:0] pressed;

  key_state_t          st_q   [NUM_KEYS];
  key_state_t          st_d   [NUM_KEYS];
  logic [DB_W-1:0]     db_q   [NUM_KEYS];
  logic [DB_W-1:0]     db_d   [NUM_KEYS];
  logic [HOLD_W-1:0]   hold_q [NUM_KEYS];
  logic [HOLD_W-1:0]   hold_d [NUM_KEYS];
  logic [NUM_KEYS-1:0] long_flag_q, long_flag_d;
  logic [NUM_KEYS-1:0] level_q, level_d;
  logic [NUM_KEYS-1:0] press_q, press_d;
  logic [NUM_KEYS-1:0] release_q, release_d;
  logic [NUM_KEYS-1:0] long_q, long_d;

  logic [1:0] mode_q, mode_d;
  logic [1:0] speed_q, speed_d;
  logic       changed_q, changed_d;

  // Stage: two-flop synchroniser on the raw pins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= SYNC_IDLE;
      sync2_q <= SYNC_IDLE;
    end else begin
      sync1_q <= bus.keys_in;
      sync2_q <= sync1_q;
    end
  end

  assign pressed = (KEY_ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;

  // Stage: per-key debounce FSMs and registered events
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        st_q[k]   <= IDLE;
        db_q[k]   <= '0;
        hold_q[k] <= '0;
      end
      long_flag_q <= '0;
      level_q     <= '0;
      press_q     <= '0;
      release_q   <= '0;
      long_q      <= '0;
    end else begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        st_q[k]   <= st_d[k];
        db_q[k]   <= db_d[k];
        hold_q[k] <= hold_d[k];
      end
      long_flag_q <= long_flag_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
    end
  end

  always_comb begin
    long_flag_d = long_flag_q;
    level_d     = level_q;
    press_d     = '0;
    release_d   = '0;
    long_d      = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      st_d[k]   = st_q[k];
      db_d[k]   = db_q[k];
      hold_d[k] = hold_q[k];
      case (st_q[k])
        IDLE: begin
          if (pressed[k]) begin
            st_d[k] = PRESS_WAIT;
            db_d[k] = '0;
          end
        end
        PRESS_WAIT: begin
          if (!pressed[k]) begin
            st_d[k] = IDLE;
          end else if (db_q[k] == DB_LAST) begin
            st_d[k]        = HELD;
            press_d[k]     = 1'b1;
            level_d[k]     = 1'b1;
            hold_d[k]      = '0;
            long_flag_d[k] = 1'b0;
          end else begin
            db_d[k] = db_q[k] + 1'b1;
          end
        end
        HELD: begin
          // The threshold test looks at the held time accumulated so far,
          // whichever way the pin goes this cycle.
          if (hold_q[k] == HOLD_LAST && !long_flag_q[k]) begin
            long_d[k]      = 1'b1;
            long_flag_d[k] = 1'b1;
          end
          if (!pressed[k]) begin
            st_d[k] = RELEASE_WAIT;
            db_d[k] = '0;
          end else if (hold_q[k] != HOLD_LAST) begin
            hold_d[k] = hold_q[k] + 1'b1;
          end
        end
        RELEASE_WAIT: begin
          // A bounce back to pressed resumes the same press: hold time and
          // long flag survive, and no new press event is raised.
          if (pressed[k]) begin
            st_d[k] = HELD;
          end else if (db_q[k] == DB_LAST) begin
            st_d[k]      = IDLE;
            release_d[k] = 1'b1;
            level_d[k]   = 1'b0;
          end else begin
            db_d[k] = db_q[k] + 1'b1;
          end
        end
        default: st_d[k] = IDLE;
      endcase
    end
  end

  // Stage: mode/speed update from the registered key events
  always_comb begin
    mode_d  = mode_q;
    speed_d = speed_q;
    if (long_q[1]) begin
      mode_d  = '0;
      speed_d = '0;
    end else if (press_q[0]) begin
      mode_d = (mode_q == MODE_LAST) ? 2'd0 : mode_q + 2'd1;
    end
    // long_flag still describes the press that just ended.
    if (release_q[1] && !long_flag_q[1]) begin
      speed_d = speed_q + 2'd1;
    end
    changed_d = (mode_d != mode_q) || (speed_d != speed_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q    <= '0;
      speed_q   <= '0;
      changed_q <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      speed_q   <= speed_d;
      changed_q <= changed_d;
    end
  end

  assign bus.key_level    = level_q;
  assign bus.key_press    = press_q;
  assign bus.key_release  = release_q;
  assign bus.key_long     = long_q;
  assign bus.mode         = mode_q;
  assign bus.speed        = speed_q;
  assign bus.mode_changed = changed_q;

endmodule
